// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM port-0 arbiter.
// Holds the arbiter state enum, macro bus widths and the muxed beat bundle.
package sram_arb_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } beat_t;

endpackage

// File: rtl/sram_port0_arbiter_if.sv
// Requester-side bus of the SRAM port-0 arbiter.
// master: requester drives req/we/wmask/addr/wdata/lock; slave: arbiter returns gnt/rvalid/rdata.
interface sram_port0_arbiter_if;
    import sram_arb_pkg::*;

    logic                  req;
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  lock;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, wmask, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, wmask, addr, wdata, lock,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/sram_arb_rr.sv
// Two-way round-robin arbiter with a bounded burst lock.
// Ports: clk, rst, req[1:0], lock[1:0] in; gnt[1:0] out (combinational, one-hot or zero).
module sram_arb_rr
    import sram_arb_pkg::*;
#(
    parameter int MAX_LOCK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LOCK);

    arb_state_e    state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          own_vld;
    logic          own;
    logic          cont;
    logic          g_vld;
    logic          g_idx;
    logic [CW-1:0] cnt_n;

    always_comb begin
        gnt     = '0;
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        own_vld = (state_q != IDLE);
        own     = (state_q == OWN1);
        cont    = own_vld & req[own];
        g_vld   = 1'b0;
        g_idx   = 1'b0;

        if (cont) begin
            g_vld = 1'b1;
            g_idx = own;
        end else begin
            g_vld = |req;
            g_idx = (&req) ? rr_q : req[1];
            // Owner dropped req: release and re-arbitrate this cycle.
            if (own_vld) begin
                state_d = IDLE;
                cnt_d   = '0;
                rr_d    = ~own;
            end
        end

        if (rst) begin
            g_vld = 1'b0;
        end

        cnt_n = (cont ? cnt_q : '0) + CW'(1);

        if (g_vld) begin
            gnt[g_idx] = 1'b1;
            if (lock[g_idx] && (cnt_n != MAX_C)) begin
                state_d = g_idx ? OWN1 : OWN0;
                cnt_d   = cnt_n;
            end else begin
                // Unlocked beat or lock budget exhausted.
                state_d = IDLE;
                cnt_d   = '0;
                rr_d    = ~g_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_port0_arbiter.sv
// Shares port 0 of a 32x256 1rw1r SRAM macro between two requesters.
// Ports: clk, rst; m0/m1 requester buses; sram_* macro port 0; p1_* port-1 snoop; collision pulse.
module sram_port0_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_LOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port0_arbiter_if.slave   m0,
    sram_port0_arbiter_if.slave   m1,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    input  logic                  p1_csb,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic                  collision
);

    logic [1:0] gnt;
    beat_t      b0, b1, bsel;
    logic       g_any;
    logic [1:0] rvalid_q, rvalid_d;
    logic       coll_q, coll_d;

    sram_arb_rr #(
        .MAX_LOCK (MAX_LOCK)
    ) u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  ({m1.req, m0.req}),
        .lock ({m1.lock, m0.lock}),
        .gnt  (gnt)
    );

    assign b0 = '{we: m0.we, wmask: m0.wmask, addr: m0.addr, wdata: m0.wdata};
    assign b1 = '{we: m1.we, wmask: m1.wmask, addr: m1.addr, wdata: m1.wdata};

    always_comb begin
        bsel        = gnt[1] ? b1 : b0;
        g_any       = |gnt;
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (g_any) begin
            sram_csb0  = 1'b0;
            sram_web0  = ~bsel.we;
            sram_addr0 = bsel.addr;
            if (bsel.we) begin
                sram_wmask0 = bsel.wmask;
                sram_din0   = bsel.wdata;
            end
        end
        rvalid_d = gnt & {~b1.we, ~b0.we};
        coll_d   = g_any & bsel.we & ~p1_csb & (p1_addr == bsel.addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            coll_q   <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            coll_q   <= coll_d;
        end
    end

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    // A reset in the data cycle drops the pending read response.
    assign m0.rvalid = rvalid_q[0] & ~rst;
    assign m1.rvalid = rvalid_q[1] & ~rst;
    assign m0.rdata  = sram_dout0;
    assign m1.rdata  = sram_dout0;
    assign collision = coll_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Scoreboard bench for sram_port0_arbiter with a behavioural 1rw1r macro.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_sram_port0_arbiter;
    import sram_arb_pkg::*;

    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0;
    logic        p1_csb;
    logic [7:0]  p1_addr;
    logic        collision;

    always #5 clk = ~clk;

    sram_port0_arbiter_if m0_if ();
    sram_port0_arbiter_if m1_if ();

    sram_port0_arbiter #(.MAX_LOCK(ML)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .sram_csb0   (csb0),
        .sram_web0   (web0),
        .sram_wmask0 (wmask0),
        .sram_addr0  (addr0),
        .sram_din0   (din0),
        .sram_dout0  (dout0),
        .p1_csb      (p1_csb),
        .p1_addr     (p1_addr),
        .collision   (collision)
    );

    // Macro model: inputs latched on posedge, write lands on the following negedge.
    logic [31:0] mem [256];
    logic        wp = 1'b0;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wm;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        wp <= 1'b0;
        if (!csb0) begin
            if (!web0) begin
                wp <= 1'b1;
                wa <= addr0;
                wd <= din0;
                wm <= wmask0;
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    always @(negedge clk) begin
        if (wp)
            for (int b = 0; b < 4; b++)
                if (wm[b]) mem[wa][b*8 +: 8] = wd[b*8 +: 8];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    rd_t         q0[$];
    rd_t         q1[$];
    logic [31:0] mm [256];
    int          own = -1;
    int          rr = 0;
    int          beats = 0;
    bit          coll_exp = 1'b0;
    bit          coll_known = 1'b0;
    int          last_g = -1;

    initial for (int i = 0; i < 256; i++) mm[i] = 32'h0;

    always @(negedge clk) begin
        bit          rq[2], lk[2], we[2];
        logic [3:0]  mk[2];
        logic [7:0]  ad[2];
        logic [31:0] wdt[2];
        int          g;
        rd_t         e;
        rq[0] = m0_if.req;   rq[1] = m1_if.req;
        lk[0] = m0_if.lock;  lk[1] = m1_if.lock;
        we[0] = m0_if.we;    we[1] = m1_if.we;
        mk[0] = m0_if.wmask; mk[1] = m1_if.wmask;
        ad[0] = m0_if.addr;  ad[1] = m1_if.addr;
        wdt[0] = m0_if.wdata; wdt[1] = m1_if.wdata;
        g = -1;

        if (coll_known) chk("collision", collision, coll_exp);

        if (!rst) begin
            if (own >= 0 && rq[own]) begin
                g = own;
            end else begin
                if (own >= 0) begin
                    rr = 1 - own;
                    own = -1;
                    beats = 0;
                end
                if (rq[0] && rq[1]) g = rr;
                else if (rq[0]) g = 0;
                else if (rq[1]) g = 1;
            end
        end

        chk("gnt0", m0_if.gnt, 32'(g == 0));
        chk("gnt1", m1_if.gnt, 32'(g == 1));
        chk("csb0", csb0, 32'(g < 0));

        if (g >= 0) begin
            chk("web0", web0, 32'(!we[g]));
            chk("addr0", addr0, ad[g]);
            chk("wmask0", wmask0, we[g] ? mk[g] : 4'h0);
            if (we[g]) begin
                chk("din0", din0, wdt[g]);
                for (int b = 0; b < 4; b++)
                    if (mk[g][b]) mm[ad[g]][b*8 +: 8] = wdt[g][b*8 +: 8];
            end else begin
                e.due = cyc + 1;
                e.data = mm[ad[g]];
                if (g == 0) q0.push_back(e);
                else q1.push_back(e);
            end
            if (lk[g]) begin
                beats = (own == g) ? beats + 1 : 1;
                if (beats >= ML) begin
                    own = -1;
                    beats = 0;
                    rr = 1 - g;
                end else begin
                    own = g;
                end
            end else begin
                own = -1;
                beats = 0;
                rr = 1 - g;
            end
        end else begin
            chk("web0_idle", web0, 32'd1);
            chk("addr0_idle", addr0, 32'd0);
            chk("wmask0_idle", wmask0, 32'd0);
            chk("din0_idle", din0, 32'd0);
        end

        coll_exp = (g >= 0) && we[g] && !p1_csb && (p1_addr == ad[g]);
        coll_known = 1'b1;
        if (rst) begin
            own = -1;
            rr = 0;
            beats = 0;
        end
        last_g = g;
    end

    // Monitor: pops expected read responses when they fall due.
    task automatic mon(int m);
        logic        rv;
        logic [31:0] rd;
        bit          has;
        rd_t         e;
        rv  = (m == 1) ? m1_if.rvalid : m0_if.rvalid;
        rd  = (m == 1) ? m1_if.rdata : m0_if.rdata;
        has = 1'b0;
        if (m == 0 && q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            has = 1'b1;
        end
        if (m == 1 && q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            has = 1'b1;
        end
        if (has && !rst) begin
            chk($sformatf("rvalid%0d", m), rv, 32'd1);
            chk($sformatf("rdata%0d", m), rd, e.data);
        end else begin
            chk($sformatf("rvalid%0d_quiet", m), rv, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        #1;
        mon(0);
        mon(1);
    end

    task automatic set_m(int m, bit r, bit w, logic [3:0] mk,
                         logic [7:0] a, logic [31:0] d, bit l);
        if (m == 0) begin
            m0_if.req = r; m0_if.we = w; m0_if.wmask = mk;
            m0_if.addr = a; m0_if.wdata = d; m0_if.lock = l;
        end else begin
            m1_if.req = r; m1_if.we = w; m1_if.wmask = mk;
            m1_if.addr = a; m1_if.wdata = d; m1_if.lock = l;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit h0[8];
    bit h1[8];

    initial begin
        rst = 1'b1;
        p1_csb = 1'b1;
        p1_addr = 8'h0;
        set_m(0, 1, 0, 4'h0, 8'h01, 32'h0, 0);
        set_m(1, 1, 0, 4'h0, 8'h02, 32'h0, 0);
        tick(); tick(); tick();
        rst = 1'b0;

        // Full-word write then read back.
        set_m(1, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        set_m(0, 1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 0);
        tick();
        set_m(0, 1, 0, 4'h0, 8'h10, 32'h0, 0);
        tick();
        set_m(0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        @(negedge clk);
        chk("p2_rvalid", m0_if.rvalid, 32'd1);
        chk("p2_rdata", m0_if.rdata, 32'hDEADBEEF);
        tick();

        // Partial byte-mask write.
        set_m(0, 1, 1, 4'hF, 8'h11, 32'h11223344, 0);
        tick();
        set_m(0, 1, 1, 4'b0010, 8'h11, 32'h0000AB00, 0);
        tick();
        set_m(0, 1, 0, 4'h0, 8'h11, 32'h0, 0);
        tick();
        set_m(0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        @(negedge clk);
        chk("p3_rdata", m0_if.rdata, 32'h1122AB44);
        tick();

        // Both reading: strict alternation, m1 first since m0 went last.
        set_m(0, 1, 0, 4'h0, 8'h10, 32'h0, 0);
        set_m(1, 1, 0, 4'h0, 8'h11, 32'h0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            h1[i] = m1_if.gnt;
            tick();
        end
        for (int i = 0; i < 8; i++) chk($sformatf("p4_alt%0d", i), h1[i], 32'(i % 2 == 0));
        set_m(0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        set_m(1, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        tick();

        // Locked burst bounded at ML beats.
        set_m(1, 1, 0, 4'h0, 8'h10, 32'h0, 1);
        @(negedge clk);
        h0[0] = m0_if.gnt;
        h1[0] = m1_if.gnt;
        tick();
        set_m(0, 1, 0, 4'h0, 8'h11, 32'h0, 0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            h0[i] = m0_if.gnt;
            h1[i] = m1_if.gnt;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p5_m1_%0d", i), h1[i], 32'(i < 4));
            chk($sformatf("p5_m0_%0d", i), h0[i], 32'(i == 4));
        end
        set_m(0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        set_m(1, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        tick();

        // Port-1 collision.
        p1_csb = 1'b0;
        p1_addr = 8'h20;
        set_m(0, 1, 1, 4'hF, 8'h20, 32'hCAFEF00D, 0);
        tick();
        p1_addr = 8'h21;
        @(negedge clk);
        chk("p6_coll_hit", collision, 32'd1);
        tick();
        set_m(0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        p1_csb = 1'b1;
        @(negedge clk);
        chk("p6_coll_miss", collision, 32'd0);
        tick();

        // Reset right after a locked read grant.
        set_m(1, 1, 0, 4'h0, 8'h10, 32'h0, 1);
        tick();
        rst = 1'b1;
        set_m(0, 1, 0, 4'h0, 8'h11, 32'h0, 0);
        @(negedge clk);
        chk("p7_rst_rvalid", m1_if.rvalid, 32'd0);
        chk("p7_rst_gnt", {m1_if.gnt, m0_if.gnt}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("p7_m0_first", m0_if.gnt, 32'd1);
        tick();
        set_m(0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        set_m(1, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        tick();

        // Randomized traffic on a small address window.
        for (int i = 0; i < 600; i++) begin
            for (int m = 0; m < 2; m++) begin
                bit cur;
                cur = (m == 0) ? m0_if.req : m1_if.req;
                if (!cur || last_g == m)
                    set_m(m, $urandom_range(0, 3) != 0, 1'($urandom % 2),
                          4'($urandom), 8'h20 + 8'($urandom % 4),
                          $urandom, ($urandom % 4) == 0);
            end
            p1_csb = 1'($urandom % 2);
            p1_addr = 8'h20 + 8'($urandom % 4);
            rst = ($urandom % 97) == 0;
            tick();
        end

        rst = 1'b0;
        p1_csb = 1'b1;
        set_m(0, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        set_m(1, 0, 0, 4'h0, 8'h0, 32'h0, 0);
        tick(); tick(); tick();
        chk("queues_drained", q0.size() + q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
